exception_ctrl: RTL

- Owns CPSR and the banked SPSRs, and sequences exception entry and return.
- Sits directly upstream of the banked register file. Drives its mode bits `M`, its register write port (`write_reg`/`w_addr`/`w_data`) and its PC write port (`write_pc`/`pc_data`).
- On an accepted exception: switches mode, then writes the banked LR, then loads the vector PC. On `eret`: restores CPSR from the current mode's SPSR and writes the return PC.

---
 rtl/exception_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: owns CPSR and the banked SPSRs, and sequences exception
// entry (mode switch, banked LR write, vector PC load) and exception return.
// Optional build macro EXC_HIVEC_EN adds the `hivec` input, which selects the
// high vector table at 32'hFFFF_0000 when set.
module exception_ctrl #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
  parameter logic [31:0] LR_OFS      = 32'd4,
  parameter logic [31:0] DABT_LR_OFS = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_dabt,
  input  logic        req_fiq,
  input  logic        req_irq,
  input  logic        req_pabt,
  input  logic        req_und,
  input  logic        req_svc,
  input  logic [31:0] cur_pc,
  input  logic        eret,
  input  logic [31:0] ret_addr,
  input  logic        msr_we,
  input  logic [31:0] msr_data,
`ifdef EXC_HIVEC_EN
  input  logic        hivec,
`endif
  output logic [31:0] cpsr,
  output logic [4:0]  M,
  output logic        write_reg,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic        write_pc,
  output logic [31:0] pc_data,
  output logic        busy,
  output logic        ack,
  output logic [2:0]  exc_id,
  output logic        eret_done,
  output logic        eret_err
);

  typedef enum logic [2:0] {IDLE, ENTER, SAVE_LR, VECTOR, RET} state_t;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  state_t      state_r;
  logic [2:0]  id_r;
  logic [31:0] lr_r;
  logic [31:0] spsr_fiq_r, spsr_irq_r, spsr_svc_r, spsr_abt_r, spsr_und_r;

  logic        take_s;
  logic [2:0]  win_id_s;
  logic [31:0] lr_s;
  logic [31:0] base_s;
  logic        has_spsr_s;
  logic [31:0] cur_spsr_s;

  // Mode entered for each exception id.
  function automatic logic [4:0] target_mode(input logic [2:0] id);
    case (id)
      3'd0:    return MODE_ABT;
      3'd1:    return MODE_FIQ;
      3'd2:    return MODE_IRQ;
      3'd3:    return MODE_ABT;
      3'd4:    return MODE_UND;
      3'd5:    return MODE_SVC;
      default: return MODE_SVC;
    endcase
  endfunction

  // Vector table offset for each exception id.
  function automatic logic [31:0] vector_ofs(input logic [2:0] id);
    case (id)
      3'd0:    return 32'h0000_0010;
      3'd1:    return 32'h0000_001C;
      3'd2:    return 32'h0000_0018;
      3'd3:    return 32'h0000_000C;
      3'd4:    return 32'h0000_0004;
      3'd5:    return 32'h0000_0008;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign M = cpsr[4:0];

  // Pick the highest-priority unmasked request (I masks irq, F masks fiq).
  always_comb begin
    take_s   = 1'b1;
    win_id_s = 3'd0;
    if (req_dabt) begin
      win_id_s = 3'd0;
    end else if (req_fiq && !cpsr[6]) begin
      win_id_s = 3'd1;
    end else if (req_irq && !cpsr[7]) begin
      win_id_s = 3'd2;
    end else if (req_pabt) begin
      win_id_s = 3'd3;
    end else if (req_und) begin
      win_id_s = 3'd4;
    end else if (req_svc) begin
      win_id_s = 3'd5;
    end else begin
      take_s   = 1'b0;
      win_id_s = 3'd0;
    end
  end

  // Return address saved into the banked LR; data abort uses a larger offset.
  always_comb begin
    if (win_id_s == 3'd0) begin
      lr_s = cur_pc + DABT_LR_OFS;
    end else begin
      lr_s = cur_pc + LR_OFS;
    end
  end

  // Vector table base, optionally relocated to the high vectors.
  always_comb begin
`ifdef EXC_HIVEC_EN
    if (hivec) begin
      base_s = 32'hFFFF_0000;
    end else begin
      base_s = VECTOR_BASE;
    end
`else
    base_s = VECTOR_BASE;
`endif
  end

  // SPSR of the current mode; usr, sys and unknown encodings have none.
  always_comb begin
    has_spsr_s = 1'b1;
    cur_spsr_s = 32'h0000_0000;
    case (cpsr[4:0])
      MODE_FIQ: cur_spsr_s = spsr_fiq_r;
      MODE_IRQ: cur_spsr_s = spsr_irq_r;
      MODE_SVC: cur_spsr_s = spsr_svc_r;
      MODE_ABT: cur_spsr_s = spsr_abt_r;
      MODE_UND: cur_spsr_s = spsr_und_r;
      default:  has_spsr_s = 1'b0;
    endcase
  end

  // Sequencer: state, CPSR/SPSR updates and registered write-port strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      id_r       <= 3'd0;
      lr_r       <= 32'h0000_0000;
      cpsr       <= 32'h0000_00D3;
      spsr_fiq_r <= 32'h0000_0000;
      spsr_irq_r <= 32'h0000_0000;
      spsr_svc_r <= 32'h0000_0000;
      spsr_abt_r <= 32'h0000_0000;
      spsr_und_r <= 32'h0000_0000;
      busy       <= 1'b0;
      write_reg  <= 1'b0;
      w_addr     <= 4'd0;
      w_data     <= 32'h0000_0000;
      write_pc   <= 1'b0;
      pc_data    <= 32'h0000_0000;
      ack        <= 1'b0;
      exc_id     <= 3'd0;
      eret_done  <= 1'b0;
      eret_err   <= 1'b0;
    end else begin
      write_reg <= 1'b0;
      w_addr    <= 4'd0;
      w_data    <= 32'h0000_0000;
      write_pc  <= 1'b0;
      pc_data   <= 32'h0000_0000;
      ack       <= 1'b0;
      exc_id    <= 3'd0;
      eret_done <= 1'b0;
      eret_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (take_s) begin
            id_r    <= win_id_s;
            lr_r    <= lr_s;
            state_r <= ENTER;
            busy    <= 1'b1;
          end else if (eret) begin
            state_r <= RET;
            busy    <= 1'b1;
            if (has_spsr_s) begin
              write_pc  <= 1'b1;
              pc_data   <= ret_addr;
              eret_done <= 1'b1;
            end else begin
              eret_err <= 1'b1;
            end
          end else if (msr_we) begin
            if (cpsr[4:0] == MODE_USR) begin
              cpsr[31:28] <= msr_data[31:28];
            end else begin
              cpsr <= msr_data;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ENTER: begin
          case (target_mode(id_r))
            MODE_FIQ: spsr_fiq_r <= cpsr;
            MODE_IRQ: spsr_irq_r <= cpsr;
            MODE_ABT: spsr_abt_r <= cpsr;
            MODE_UND: spsr_und_r <= cpsr;
            default:  spsr_svc_r <= cpsr;
          endcase
          cpsr <= {cpsr[31:8], 1'b1, ((id_r == 3'd1) ? 1'b1 : cpsr[6]),
                   cpsr[5], target_mode(id_r)};
          write_reg <= 1'b1;
          w_addr    <= 4'd14;
          w_data    <= lr_r;
          state_r   <= SAVE_LR;
        end
        SAVE_LR: begin
          write_pc <= 1'b1;
          pc_data  <= base_s + vector_ofs(id_r);
          ack      <= 1'b1;
          exc_id   <= id_r;
          state_r  <= VECTOR;
        end
        VECTOR: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        RET: begin
          if (has_spsr_s) begin
            cpsr <= cur_spsr_s;
          end else begin
            cpsr <= cpsr;
          end
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
